dmem_responder: RTL and testbench

- Data-memory responder on the core's load/store port: the far end of mem_valid / mem_addr / mem_wdata / mem_wstrb / mem_rdata.
- Word-organised synchronous RAM with byte-lane writes and a programmable wait-state count.
- Adds a mem_ready/mem_fault completion handshake; the top level inverts mem_ready into the core's hlt stall while a request is outstanding.

---
 rtl/dmem_responder.sv | 139 +++++++++++++
 tb/tb_dmem_responder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Brief    : Data-memory responder for the core load/store port. Word RAM
//             with byte-lane writes, programmable wait states and a
//             ready/fault completion handshake.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] ADDR_BASE   = 32'h0001_0000,
  parameter int          WAIT_STATES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_ready,
  output logic        mem_fault,
  output logic        busy
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // 33-bit window bounds so the top of the window cannot wrap to zero
  localparam logic [32:0] c_LO        = {1'b0, ADDR_BASE};
  localparam logic [32:0] c_HI        = c_LO + (33'(DEPTH_WORDS) << 2);
  localparam logic [3:0]  c_WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wstrb;
  logic          r_fault;
  logic [31:0]   r_rdata;
  logic [31:0]   r_mem [DEPTH_WORDS];

  logic          w_in_fault;
  logic [31:0]   w_off;
  logic [AW-1:0] w_in_idx;
  logic          w_idle;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_wdata;
  logic [3:0]    w_wstrb;
  logic          w_fault;
  logic          w_go;
  logic          w_commit;
  logic          w_read;
  logic          w_resp;

  // Decode the incoming request: fault check and word index
  assign w_in_fault = (mem_addr[1:0] != 2'b00)
                   || ({1'b0, mem_addr} <  c_LO)
                   || ({1'b0, mem_addr} >= c_HI);
  assign w_off      = mem_addr - ADDR_BASE;
  assign w_in_idx   = AW'(w_off >> 2);

  // With zero wait states the RAM is accessed straight from IDLE, so the
  // live request fields are used there instead of the latched copies.
  assign w_idle  = (r_state == S_IDLE);
  assign w_idx   = w_idle ? w_in_idx   : r_idx;
  assign w_wdata = w_idle ? mem_wdata  : r_wdata;
  assign w_wstrb = w_idle ? mem_wstrb  : r_wstrb;
  assign w_fault = w_idle ? w_in_fault : r_fault;

  // Edge that moves the FSM into RESP; the RAM is accessed on this edge
  assign w_go = mem_valid &&
                ((w_idle && (WAIT_STATES == 0)) ||
                 ((r_state == S_WAIT) && (r_cnt == c_WAIT_LAST)));
  // rst beats a write landing on the same edge
  assign w_commit = w_go && !rst && !w_fault && (w_wstrb != 4'b0000);
  assign w_read   = w_go && !w_fault && (w_wstrb == 4'b0000);

  // Request FSM, wait counter, request latch and registered read data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_fault <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      if (w_go) begin
        r_rdata <= w_read ? r_mem[w_idx] : 32'd0;
      end
      case (r_state)
        S_IDLE: begin
          r_cnt <= 4'd0;
          if (mem_valid) begin
            r_idx   <= w_in_idx;
            r_wdata <= mem_wdata;
            r_wstrb <= mem_wstrb;
            r_fault <= w_in_fault;
            r_state <= (WAIT_STATES > 0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          if (!mem_valid) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
          end else if (r_cnt == c_WAIT_LAST) begin
            r_state <= S_RESP;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Byte-lane RAM write; contents survive reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_commit && w_wstrb[i]) begin
        r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  // Completion outputs are suppressed while rst is high
  assign w_resp    = (r_state == S_RESP) && !rst;
  assign mem_ready = w_resp;
  assign mem_fault = w_resp && r_fault;
  assign mem_rdata = (w_resp && !r_fault) ? r_rdata : 32'd0;
  assign busy      = (r_state == S_WAIT) || (r_state == S_RESP);

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Brief    : Directed self-checking bench for dmem_responder. Instance 1 runs
//             with one wait state, instance 0 with none.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        vld [2];
  logic [31:0] adr [2];
  logic [31:0] wd  [2];
  logic [3:0]  st  [2];
  logic [31:0] rd  [2];
  logic        rdy [2];
  logic        flt [2];
  logic        bsy [2];

  int n_pass  = 0;
  int n_total = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .ADDR_BASE(32'h0001_0000), .WAIT_STATES(1)) u_dut1 (
    .clk(clk), .rst(rst), .mem_valid(vld[1]), .mem_addr(adr[1]), .mem_wdata(wd[1]),
    .mem_wstrb(st[1]), .mem_rdata(rd[1]), .mem_ready(rdy[1]), .mem_fault(flt[1]), .busy(bsy[1])
  );

  dmem_responder #(.DEPTH_WORDS(1024), .ADDR_BASE(32'h0001_0000), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .mem_valid(vld[0]), .mem_addr(adr[0]), .mem_wdata(wd[0]),
    .mem_wstrb(st[0]), .mem_rdata(rd[0]), .mem_ready(rdy[0]), .mem_fault(flt[0]), .busy(bsy[0])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and hold it until ready or the cycle budget runs out
  task automatic do_req(input int sel, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] r, output logic f,
                        output int lat, output logic seen);
    int n;
    n = 0; seen = 1'b0; lat = 0; r = 32'hx; f = 1'bx;
    vld[sel] = 1'b1; adr[sel] = a; wd[sel] = d; st[sel] = s;
    while (!seen && n < 20) begin
      step();
      n++;
      if (rdy[sel] === 1'b1) begin
        seen = 1'b1; lat = n; r = rd[sel]; f = flt[sel];
      end
    end
    vld[sel] = 1'b0; wd[sel] = 32'd0; st[sel] = 4'd0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_total++; if (rdy[1] !== 1'b0) $display("FAIL reset_ready_in_rst: got %b want 0", rdy[1]); else n_pass++;
    rst = 1'b0;
    step();
    n_total++; if (rdy[1] !== 1'b0) $display("FAIL reset_ready: got %b want 0", rdy[1]); else n_pass++;
    n_total++; if (flt[1] !== 1'b0) $display("FAIL reset_fault: got %b want 0", flt[1]); else n_pass++;
    n_total++; if (rd[1] !== 32'd0) $display("FAIL reset_rdata: got %h want 0", rd[1]); else n_pass++;
    n_total++; if (bsy[1] !== 1'b0) $display("FAIL reset_busy: got %b want 0", bsy[1]); else n_pass++;
    n_total++; if (bsy[0] !== 1'b0) $display("FAIL reset_busy0: got %b want 0", bsy[0]); else n_pass++;
  endtask

  task automatic test_write_read();
    logic [31:0] r; logic f, seen; int lat;
    do_req(1, 32'h0001_0010, 32'hDEAD_BEEF, 4'hF, r, f, lat, seen);
    n_total++; if (seen !== 1'b1) $display("FAIL wr_ready_seen: got %b want 1", seen); else n_pass++;
    n_total++; if (lat != 2) $display("FAIL wr_latency: got %0d want 2", lat); else n_pass++;
    n_total++; if (f !== 1'b0) $display("FAIL wr_fault: got %b want 0", f); else n_pass++;
    n_total++; if (r !== 32'd0) $display("FAIL wr_rdata_zero: got %h want 0", r); else n_pass++;
    do_req(1, 32'h0001_0010, 32'd0, 4'h0, r, f, lat, seen);
    n_total++; if (r !== 32'hDEAD_BEEF) $display("FAIL rd_data: got %h want deadbeef", r); else n_pass++;
    n_total++; if (lat != 2) $display("FAIL rd_latency: got %0d want 2", lat); else n_pass++;
  endtask

  task automatic test_byte_lanes();
    logic [31:0] r; logic f, seen; int lat;
    do_req(1, 32'h0001_0030, 32'h1122_3344, 4'hF, r, f, lat, seen);
    do_req(1, 32'h0001_0030, 32'hAABB_CCDD, 4'b0101, r, f, lat, seen);
    do_req(1, 32'h0001_0030, 32'd0, 4'h0, r, f, lat, seen);
    n_total++; if (r !== 32'h11BB_33DD) $display("FAIL lanes_0101: got %h want 11bb33dd", r); else n_pass++;
    do_req(1, 32'h0001_0030, 32'h9988_7766, 4'b1010, r, f, lat, seen);
    do_req(1, 32'h0001_0030, 32'd0, 4'h0, r, f, lat, seen);
    n_total++; if (r !== 32'h99BB_77DD) $display("FAIL lanes_1010: got %h want 99bb77dd", r); else n_pass++;
  endtask

  task automatic test_faults();
    logic [31:0] r; logic f, seen; int lat;
    do_req(1, 32'h0001_0002, 32'd0, 4'h0, r, f, lat, seen);
    n_total++; if (seen !== 1'b1 || f !== 1'b1) $display("FAIL flt_misaligned: got seen=%b fault=%b want 1/1", seen, f); else n_pass++;
    n_total++; if (r !== 32'd0) $display("FAIL flt_misaligned_rdata: got %h want 0", r); else n_pass++;
    do_req(1, 32'h0000_FFFC, 32'h1234_5678, 4'hF, r, f, lat, seen);
    n_total++; if (f !== 1'b1) $display("FAIL flt_below_base: got %b want 1", f); else n_pass++;
    do_req(1, 32'h0001_1000, 32'd0, 4'h0, r, f, lat, seen);
    n_total++; if (f !== 1'b1) $display("FAIL flt_above_top: got %b want 1", f); else n_pass++;
    // misaligned write into a live word must leave it alone
    do_req(1, 32'h0001_0012, 32'h0000_0000, 4'hF, r, f, lat, seen);
    n_total++; if (f !== 1'b1) $display("FAIL flt_misaligned_wr: got %b want 1", f); else n_pass++;
    do_req(1, 32'h0001_0010, 32'd0, 4'h0, r, f, lat, seen);
    n_total++; if (r !== 32'hDEAD_BEEF) $display("FAIL flt_ram_untouched: got %h want deadbeef", r); else n_pass++;
    // last word of the window is legal
    do_req(1, 32'h0001_0FFC, 32'h5A5A_A5A5, 4'hF, r, f, lat, seen);
    n_total++; if (f !== 1'b0) $display("FAIL top_word_fault: got %b want 0", f); else n_pass++;
    do_req(1, 32'h0001_0FFC, 32'd0, 4'h0, r, f, lat, seen);
    n_total++; if (r !== 32'h5A5A_A5A5) $display("FAIL top_word_data: got %h want 5a5aa5a5", r); else n_pass++;
  endtask

  task automatic test_abort();
    logic [31:0] r; logic f, seen; int lat;
    do_req(1, 32'h0001_0020, 32'h1234_5678, 4'hF, r, f, lat, seen);
    vld[1] = 1'b1; adr[1] = 32'h0001_0020; wd[1] = 32'hCAFE_F00D; st[1] = 4'hF;
    step();
    n_total++; if (bsy[1] !== 1'b1) $display("FAIL abort_busy_wait: got %b want 1", bsy[1]); else n_pass++;
    vld[1] = 1'b0;
    step();
    n_total++; if (rdy[1] !== 1'b0) $display("FAIL abort_no_ready: got %b want 0", rdy[1]); else n_pass++;
    step();
    n_total++; if (rdy[1] !== 1'b0 || bsy[1] !== 1'b0) $display("FAIL abort_idle: got ready=%b busy=%b want 0/0", rdy[1], bsy[1]); else n_pass++;
    st[1] = 4'h0; wd[1] = 32'd0;
    do_req(1, 32'h0001_0020, 32'd0, 4'h0, r, f, lat, seen);
    n_total++; if (r !== 32'h1234_5678) $display("FAIL abort_old_data: got %h want 12345678", r); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; logic f, seen; int lat;
    logic [31:0] exp_d [8];
    int k;
    for (int i = 0; i < 8; i++) begin
      do_req(0, 32'h0001_0000 + 32'(4*i), 32'hC0DE_0000 + 32'(i*32'h111), 4'hF, r, f, lat, seen);
    end
    n_total++; if (lat != 1) $display("FAIL ws0_latency: got %0d want 1", lat); else n_pass++;
    for (int i = 0; i < 8; i++) exp_d[i] = 32'hC0DE_0000 + 32'(((i*3)%8)*32'h111);
    k = 0;
    vld[0] = 1'b1; st[0] = 4'h0; adr[0] = 32'h0001_0000;
    for (int s = 0; s < 16; s++) begin
      step();
      n_total++; if (rdy[0] !== ((s % 2) == 0)) $display("FAIL b2b_ready_s%0d: got %b want %b", s, rdy[0], ((s % 2) == 0)); else n_pass++;
      if (rdy[0] === 1'b1 && k < 8) begin
        n_total++; if (rd[0] !== exp_d[k]) $display("FAIL b2b_data_%0d: got %h want %h", k, rd[0], exp_d[k]); else n_pass++;
        k++;
        if (k < 8) adr[0] = 32'h0001_0000 + 32'(4*((k*3)%8));
        else vld[0] = 1'b0;
      end
    end
    vld[0] = 1'b0;
    n_total++; if (k != 8) $display("FAIL b2b_count: got %0d want 8", k); else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] r; logic f, seen; int lat;
    do_req(1, 32'h0001_0040, 32'h0BAD_F00D, 4'hF, r, f, lat, seen);
    vld[1] = 1'b1; adr[1] = 32'h0001_0040; wd[1] = 32'hFFFF_FFFF; st[1] = 4'hF;
    step();
    rst = 1'b1;
    step();
    n_total++; if (rdy[1] !== 1'b0 || flt[1] !== 1'b0) $display("FAIL rstw_outputs: got ready=%b fault=%b want 0/0", rdy[1], flt[1]); else n_pass++;
    n_total++; if (bsy[1] !== 1'b0 || rd[1] !== 32'd0) $display("FAIL rstw_state: got busy=%b rdata=%h want 0/0", bsy[1], rd[1]); else n_pass++;
    rst = 1'b0; vld[1] = 1'b0; st[1] = 4'h0; wd[1] = 32'd0;
    step();
    n_total++; if (rdy[1] !== 1'b0) $display("FAIL rstw_after: got %b want 0", rdy[1]); else n_pass++;
    do_req(1, 32'h0001_0040, 32'd0, 4'h0, r, f, lat, seen);
    n_total++; if (r !== 32'h0BAD_F00D) $display("FAIL rstw_unchanged: got %h want 0badf00d", r); else n_pass++;
    // rst raised while the FSM sits in RESP hides the pulse
    vld[1] = 1'b1; adr[1] = 32'h0001_0040; st[1] = 4'h0;
    step(); step();
    rst = 1'b1;
    #1;
    n_total++; if (rdy[1] !== 1'b0) $display("FAIL rst_in_resp_ready: got %b want 0", rdy[1]); else n_pass++;
    vld[1] = 1'b0;
    step();
    rst = 1'b0;
    step();
    do_req(1, 32'h0001_0040, 32'h600D_CAFE, 4'hF, r, f, lat, seen);
    n_total++; if (seen !== 1'b1 || f !== 1'b0 || lat != 2) $display("FAIL rstw_next_req: got seen=%b fault=%b lat=%0d want 1/0/2", seen, f, lat); else n_pass++;
    do_req(1, 32'h0001_0040, 32'd0, 4'h0, r, f, lat, seen);
    n_total++; if (r !== 32'h600D_CAFE) $display("FAIL rstw_next_data: got %h want 600dcafe", r); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      vld[i] = 1'b0; adr[i] = 32'd0; wd[i] = 32'd0; st[i] = 4'd0;
    end
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_faults();
    test_abort();
    test_back_to_back();
    test_reset_mid_write();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
